// File: rtl/pipe_alu.sv
// Handshaked, registered ALU: single-cycle arithmetic/logic/shift ops plus an
// iterative WIDTH-cycle shift-add multiply, with compare and status flags.
module pipe_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [3:0]       control,
    input  logic             cmp_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             greater,
    output logic             lesser,
    output logic             equal,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SL1 = 4'b0100;
    localparam logic [3:0] OP_SR1 = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]   cnt;

    logic             accept;
    logic             is_sub;
    logic             is_arith;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic [WIDTH-1:0] acc_next;

    assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        is_sub   = (control == OP_SUB);
        shamt    = in_B[SHW-1:0];
        b_op     = is_sub ? ~in_B : in_B;
        sum      = {1'b0, in_A} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
        is_arith = 1'b0;
        alu_res  = '0;
        case (control)
            OP_AND:  alu_res = in_A & in_B;
            OP_OR:   alu_res = in_A | in_B;
            OP_SL1:  alu_res = in_A << 1;
            OP_SR1:  alu_res = in_A >> 1;
            OP_XOR:  alu_res = in_A ^ in_B;
            OP_SHL:  alu_res = in_A << shamt;
            OP_SHR:  alu_res = in_A >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(in_A) >>> shamt);
            OP_MUL:  alu_res = '0;
            default: begin
                // add, sub and the unused opcodes all take the adder path
                is_arith = 1'b1;
                alu_res  = sum[WIDTH-1:0];
            end
        endcase
        alu_carry = is_arith & sum[WIDTH];
        alu_ovf   = is_arith & (in_A[WIDTH-1] == b_op[WIDTH-1])
                             & (sum[WIDTH-1] != in_A[WIDTH-1]);
    end

    always_comb begin
        cmp_eq = (in_A == in_B);
        if (cmp_signed) begin
            cmp_gt = $signed(in_A) > $signed(in_B);
            cmp_lt = $signed(in_A) < $signed(in_B);
        end else begin
            cmp_gt = in_A > in_B;
            cmp_lt = in_A < in_B;
        end
    end

    assign acc_next = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            greater   <= 1'b0;
            lesser    <= 1'b0;
            equal     <= 1'b0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        greater <= cmp_gt;
                        lesser  <= cmp_lt;
                        equal   <= cmp_eq;
                        if (control == OP_MUL) begin
                            acc       <= '0;
                            mcand     <= in_A;
                            mplier    <= in_B;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            state     <= MUL;
                        end else begin
                            out       <= alu_res;
                            zero      <= (alu_res == '0);
                            carry     <= alu_carry;
                            overflow  <= alu_ovf;
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // last iteration's partial sum goes straight to the output
                    if (cnt == CNT_LAST) begin
                        out       <= acc_next;
                        zero      <= (acc_next == '0);
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_alu.sv
// Self-checking bench for pipe_alu: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_pipe_alu;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_A = '0;
    logic [W-1:0] in_B = '0;
    logic [3:0]   control = 4'd0;
    logic         cmp_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         greater, lesser, equal, zero, carry, overflow;

    int vectors = 0;
    int errors = 0;

    pipe_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .control(control), .cmp_signed(cmp_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .greater(greater), .lesser(lesser), .equal(equal), .zero(zero),
        .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Returns {result, greater, lesser, equal, zero, carry, overflow}
    function automatic logic [W+5:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op, input logic sgn);
        logic [W-1:0]   r;
        logic           c, o, g, l, e;
        logic signed [W+1:0] sa, sb, s;
        int unsigned    n;
        n  = {26'd0, b[5:0]};
        sa = $signed(a);
        sb = $signed(b);
        c  = 1'b0;
        o  = 1'b0;
        s  = '0;
        case (op)
            4'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                o = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a << 1;
            4'd5:  r = a >> 1;
            4'd6:  r = a ^ b;
            4'd7:  r = a << n;
            4'd8:  r = a >> n;
            4'd9:  r = (a >> n) | (a[W-1] ? ~({W{1'b1}} >> n) : '0);
            4'd10: r = a * b;
            default: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                s = sa + sb;
                o = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
            end
        endcase
        if (sgn) begin
            g = sa > sb;
            l = sa < sb;
        end else begin
            g = a > b;
            l = a < b;
        end
        e = (a == b);
        return {r, g, l, e, (r == '0), c, o};
    endfunction

    function automatic logic [W+5:0] observed();
        return {out, greater, lesser, equal, zero, carry, overflow};
    endfunction

    // Presents one operation and returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                         input logic sgn, output int waited);
        bit got;
        in_A = a; in_B = b; control = op; cmp_signed = sgn; in_valid = 1'b1;
        waited = 0;
        got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
            waited++;
        end
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL issue_timeout op=%0d in_ready never rose (required 1)", op);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_A = 64'h1234; in_B = 64'h1; control = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, observed()} !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b vec=%h required all 0",
                     in_ready, out_valid, observed());
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_accept got vld=%b rdy=%b required vld=0 rdy=1",
                     out_valid, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_boundary();
        int w;
        issue({W{1'b1}}, 64'd1, 4'd0, 1'b0, w);
        vectors++;
        if ({out_valid, observed()} !== {1'b1, 64'd0, 6'b100110}) begin
            errors++;
            $display("FAIL add_boundary got vld=%b vec=%h required vld=1 out=0 g=1 z=1 c=1",
                     out_valid, observed());
        end
    endtask

    task automatic test_signed_compare();
        int w;
        issue(64'h8000_0000_0000_0000, 64'd1, 4'd0, 1'b1, w);
        vectors++;
        if ({greater, lesser, equal} !== 3'b010) begin
            errors++;
            $display("FAIL cmp_signed got gle=%b required 010", {greater, lesser, equal});
        end
        issue(64'h8000_0000_0000_0000, 64'd1, 4'd0, 1'b0, w);
        vectors++;
        if ({greater, lesser, equal} !== 3'b100) begin
            errors++;
            $display("FAIL cmp_unsigned got gle=%b required 100", {greater, lesser, equal});
        end
    endtask

    task automatic test_shifts();
        int w;
        logic [3:0]   ops [3] = '{4'd9, 4'd8, 4'd7};
        logic [W-1:0] req [3] = '{64'hF800_0000_0000_000F, 64'h0800_0000_0000_000F,
                                  64'h0000_0000_0000_0F00};
        for (int i = 0; i < 3; i++) begin
            issue(64'h8000_0000_0000_00F0, 64'h44, ops[i], 1'b0, w);
            vectors++;
            if (out !== req[i]) begin
                errors++;
                $display("FAIL shift_op%0d got %h required %h", ops[i], out, req[i]);
            end
        end
    endtask

    task automatic test_random_ops();
        int w;
        logic [W-1:0] a, b;
        logic [3:0]   op;
        logic         sgn;
        logic [W+5:0] expv;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a[W-1] = ~a[W-1];
            do op = 4'($urandom_range(0, 15)); while (op == 4'd10);
            sgn = 1'($urandom_range(0, 1));
            expv = model(a, b, op, sgn);
            issue(a, b, op, sgn, w);
            vectors++;
            if ({out_valid, observed()} !== {1'b1, expv} || (i > 0 && w != 0)) begin
                errors++;
                $display("FAIL random_op%0d got vld=%b vec=%h wait=%0d required vld=1 vec=%h wait=0",
                         op, out_valid, observed(), w, expv);
            end
        end
    endtask

    task automatic test_mul();
        int w, cycles;
        bit rdy_seen;
        logic [W-1:0] a, b;
        logic [W+5:0] expv;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                a = 64'd12345; b = 64'd6789;
            end else begin
                a = {$urandom, $urandom}; b = {$urandom, $urandom};
            end
            expv = model(a, b, 4'd10, 1'b0);
            drain();
            out_ready = 1'b0;
            issue(a, b, 4'd10, 1'b0, w);
            cycles = 0;
            rdy_seen = 0;
            while (!out_valid && cycles < 200) begin
                if (in_ready !== 1'b0) rdy_seen = 1;
                @(posedge clk); #1;
                cycles++;
            end
            vectors++;
            if (cycles != 64 || rdy_seen) begin
                errors++;
                $display("FAIL mul_latency got cycles=%0d rdy_seen=%b required 64 and 0",
                         cycles, rdy_seen);
            end
            vectors++;
            if (observed() !== expv || (i == 0 && out !== 64'd83810205)) begin
                errors++;
                $display("FAIL mul_result got %h required %h", observed(), expv);
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== expv) begin
                errors++;
                $display("FAIL mul_hold got vld=%b rdy=%b vec=%h required 1 0 %h",
                         out_valid, in_ready, observed(), expv);
            end
            out_ready = 1'b1;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mul_consume_ready got %b required 1", in_ready);
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mul_consumed got vld=%b required 0", out_valid);
            end
        end
    endtask

    task automatic test_mul_reset();
        int w;
        bit seen;
        drain();
        issue(64'd12345, 64'd6789, 4'd10, 1'b0, w);
        repeat (29) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            if (out_valid !== 1'b0) seen = 1;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_abort got vld_seen=%b rdy=%b required 0 1", seen, in_ready);
        end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] a [4];
        logic [W-1:0] b [4];
        logic [W-1:0] q [$];
        logic [W-1:0] hold;
        logic [W-1:0] head;
        bit pat [4] = '{1, 0, 0, 1};
        bit stalled;
        int idx, consumed;
        drain();
        for (int i = 0; i < 4; i++) begin
            a[i] = {$urandom, $urandom};
            b[i] = {$urandom, $urandom};
        end
        idx = 0;
        consumed = 0;
        for (int cyc = 0; cyc < 60 && consumed < 4; cyc++) begin
            out_ready = pat[cyc % 4];
            if (idx < 4) begin
                in_valid = 1'b1; in_A = a[idx]; in_B = b[idx]; control = 4'd0; cmp_signed = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            stalled = out_valid && !out_ready;
            hold = out;
            if (out_valid && out_ready) begin
                head = (q.size() > 0) ? q.pop_front() : ~out;
                vectors++;
                if (out !== head) begin
                    errors++;
                    $display("FAIL bp_result%0d got %h required %h", consumed, out, head);
                end
                consumed++;
            end
            if (in_valid && in_ready) begin
                q.push_back(a[idx] + b[idx]);
                idx++;
            end
            @(posedge clk); #1;
            if (stalled) begin
                vectors++;
                if (out_valid !== 1'b1 || out !== hold) begin
                    errors++;
                    $display("FAIL bp_hold got vld=%b out=%h required 1 %h", out_valid, out, hold);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (consumed != 4 || q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count got consumed=%0d left=%0d vld=%b required 4 0 0",
                     consumed, q.size(), out_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add_boundary();
        test_signed_compare();
        test_shifts();
        test_random_ops();
        test_mul();
        test_mul_reset();
        test_back_pressure();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
